// File: rtl/elevator_pkg.sv
// Shared definitions for the elevator request queue: floor code width,
// reserved slot codes and the reader FSM state type.
package elevator_pkg;

  localparam int FLOOR_W = 4;

  localparam logic [FLOOR_W-1:0] EMPTY_SLOT   = 4'd0;
  localparam logic [FLOOR_W-1:0] GROUND_FLOOR = 4'd1;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_MOVE   = 3'd1;
  localparam logic [2:0] ST_DOOR   = 3'd2;
  localparam logic [2:0] ST_POP    = 3'd3;
  localparam logic [2:0] ST_SETTLE = 3'd4;

  typedef enum logic [2:0] {
    IDLE   = ST_IDLE,
    MOVE   = ST_MOVE,
    DOOR   = ST_DOOR,
    POP    = ST_POP,
    SETTLE = ST_SETTLE
  } reader_state_t;

  // A head entry names a floor only when it is non-empty and not above the top floor.
  function automatic logic floor_code_valid(input logic [FLOOR_W-1:0] code,
                                            input logic [FLOOR_W-1:0] top);
    return (code != EMPTY_SLOT) && (code <= top);
  endfunction

endpackage

// File: rtl/elevator_queue_reader_cycle_timer.sv
// Loadable down-counter shared by the travel and door phases of the reader.
module cycle_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             en,
  output logic             zero
);

  logic [WIDTH-1:0] count_reg;

  // Load wins over decrement; the counter parks at zero rather than wrapping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_value;
    end else if (en && (count_reg != '0)) begin
      count_reg <= count_reg - 1'b1;
    end
  end

  assign zero = (count_reg == '0);

endmodule

// File: rtl/elevator_queue_reader.sv
// Consumer end of the elevator request queue: serves the head entry floor by
// floor, holds the door, then pops the entry with a single shift pulse.
module elevator_queue_reader
  import elevator_pkg::*;
#(
  parameter int TRAVEL_CYCLES = 4,
  parameter int DOOR_CYCLES   = 8,
  parameter int TOP_FLOOR     = 15
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [FLOOR_W-1:0] q,
  output logic [FLOOR_W-1:0] addr,
  output logic               shift,
  output logic [FLOOR_W-1:0] floor,
  output logic               moving_up,
  output logic               moving_down,
  output logic               door_open,
  output logic               busy,
  output logic               bad_req
);

  localparam int TIMER_MAX = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
  localparam int TIMER_W   = (TIMER_MAX < 2) ? 1 : $clog2(TIMER_MAX);
  localparam logic [TIMER_W-1:0] TRAVEL_LOAD = TIMER_W'(TRAVEL_CYCLES - 1);
  localparam logic [TIMER_W-1:0] DOOR_LOAD   = TIMER_W'(DOOR_CYCLES - 1);
  localparam logic [FLOOR_W-1:0] TOP_CODE    = FLOOR_W'(TOP_FLOOR);

  reader_state_t      state_reg, state_next;
  logic [FLOOR_W-1:0] target_reg, target_next;
  logic [FLOOR_W-1:0] floor_reg, floor_next;
  logic               bad_req_reg, bad_req_next;
  logic [FLOOR_W-1:0] step_floor;
  logic [FLOOR_W-1:0] reread_target;
  logic               timer_load;
  logic               timer_en;
  logic               timer_zero;
  logic [TIMER_W-1:0] timer_value;

  cycle_timer #(.WIDTH(TIMER_W)) u_timer (
    .clk        (clk),
    .reset      (reset),
    .load       (timer_load),
    .load_value (timer_value),
    .en         (timer_en),
    .zero       (timer_zero)
  );

  always_comb begin
    state_next    = state_reg;
    target_next   = target_reg;
    floor_next    = floor_reg;
    bad_req_next  = 1'b0;
    timer_load    = 1'b0;
    timer_en      = 1'b0;
    timer_value   = TRAVEL_LOAD;
    step_floor    = (target_reg > floor_reg) ? floor_reg + 1'b1 : floor_reg - 1'b1;
    // A valid head re-read at each floor lets an inserted stop be served en route.
    reread_target = floor_code_valid(q, TOP_CODE) ? q : target_reg;

    unique case (state_reg)
      IDLE: begin
        if (q == EMPTY_SLOT) begin
          state_next = IDLE;
        end else if (q > TOP_CODE) begin
          state_next   = POP;
          bad_req_next = 1'b1;
        end else if (q == floor_reg) begin
          state_next  = DOOR;
          timer_load  = 1'b1;
          timer_value = DOOR_LOAD;
        end else begin
          state_next  = MOVE;
          target_next = q;
          timer_load  = 1'b1;
          timer_value = TRAVEL_LOAD;
        end
      end
      MOVE: begin
        if (!timer_zero) begin
          timer_en = 1'b1;
        end else begin
          floor_next  = step_floor;
          target_next = reread_target;
          timer_load  = 1'b1;
          if (step_floor == reread_target) begin
            state_next  = DOOR;
            timer_value = DOOR_LOAD;
          end else begin
            timer_value = TRAVEL_LOAD;
          end
        end
      end
      DOOR: begin
        if (timer_zero) begin
          state_next = POP;
        end else begin
          timer_en = 1'b1;
        end
      end
      POP:     state_next = SETTLE;
      SETTLE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= IDLE;
      target_reg  <= GROUND_FLOOR;
      floor_reg   <= GROUND_FLOOR;
      bad_req_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      target_reg  <= target_next;
      floor_reg   <= floor_next;
      bad_req_reg <= bad_req_next;
    end
  end

  // While moving, target never equals floor, so exactly one direction is active.
  assign addr        = EMPTY_SLOT;
  assign floor       = floor_reg;
  assign busy        = (state_reg != IDLE);
  assign shift       = (state_reg == POP);
  assign door_open   = (state_reg == DOOR);
  assign moving_up   = (state_reg == MOVE) && (target_reg > floor_reg);
  assign moving_down = (state_reg == MOVE) && (target_reg < floor_reg);
  assign bad_req     = bad_req_reg;

endmodule

// File: tb/tb_elevator_queue_reader.sv
// Bench for elevator_queue_reader: directed table, hand-written corner
// sequences, and randomized queues checked against a schedule model.
module tb_elevator_queue_reader;

  localparam int T_CYC = 4;
  localparam int D_CYC = 8;
  localparam int TOPF  = 10;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] q;
  logic [3:0] addr;
  logic       shift;
  logic [3:0] floor;
  logic       moving_up;
  logic       moving_down;
  logic       door_open;
  logic       busy;
  logic       bad_req;

  always #5 clk = ~clk;

  elevator_queue_reader #(
    .TRAVEL_CYCLES (T_CYC),
    .DOOR_CYCLES   (D_CYC),
    .TOP_FLOOR     (TOPF)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .q           (q),
    .addr        (addr),
    .shift       (shift),
    .floor       (floor),
    .moving_up   (moving_up),
    .moving_down (moving_down),
    .door_open   (door_open),
    .busy        (busy),
    .bad_req     (bad_req)
  );

  // Request RAM model: bulk load, head insert, and pop on shift.
  logic [3:0] ram [16];
  logic [3:0] load_vals [16];
  logic       load_en = 1'b1;
  logic       ins_en  = 1'b0;
  logic [3:0] ins_val = 4'd0;

  always @(posedge clk) begin
    if (load_en) begin
      for (int i = 0; i < 16; i++) ram[i] <= load_vals[i];
    end else if (ins_en) begin
      ram[0] <= ins_val;
      for (int i = 1; i < 16; i++) ram[i] <= ram[i-1];
    end else if (shift) begin
      for (int i = 0; i < 15; i++) ram[i] <= ram[i+1];
      ram[15] <= 4'd0;
    end
  end

  assign q = ram[0];

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end else begin
      $display("ok   %s: %0d", name, act);
    end
  endtask

  task automatic pulse_load();
    @(negedge clk) load_en = 1'b1;
    @(negedge clk) load_en = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk) reset = 1'b1;
    @(negedge clk) reset = 1'b0;
  endtask

  function automatic logic [9:0] pack(input logic [3:0] fl, input logic up, input logic dn,
                                      input logic dr, input logic sh, input logic bz,
                                      input logic bd);
    return {fl, up, dn, dr, sh, bz, bd};
  endfunction

  typedef struct {
    logic [3:0] req;
    int         up_c;
    int         down_c;
    int         door_c;
    int         shift_c;
    int         bad_c;
    int         busy_c;
    int         fin;
  } vec_t;

  vec_t       vecs [7];
  logic [9:0] exp_q [$];
  int         up_c, down_c, door_c, shift_c, bad_c, busy_c, both_c;
  int         started, done, bad_cnt, n, f, e, d, door_n, prev_door, inserted;
  int         doors [3];
  logic [3:0] rq [16];

  initial begin
    vecs[0] = '{4'd4,  12, 0,  8, 1, 0, 22, 4};
    vecs[1] = '{4'd4,  0,  0,  8, 1, 0, 10, 4};
    vecs[2] = '{4'd12, 0,  0,  0, 1, 1, 2,  4};
    vecs[3] = '{4'd2,  0,  8,  8, 1, 0, 18, 2};
    vecs[4] = '{4'd10, 32, 0,  8, 1, 0, 42, 10};
    vecs[5] = '{4'd11, 0,  0,  0, 1, 1, 2,  10};
    vecs[6] = '{4'd1,  0,  36, 8, 1, 0, 46, 1};

    // Reset values and an empty queue held for 20 cycles.
    reset = 1'b1;
    for (int i = 0; i < 16; i++) load_vals[i] = 4'd0;
    repeat (3) @(negedge clk);
    load_en = 1'b0;
    check("rst_floor", int'(floor), 1);
    check("rst_outs", int'({shift, door_open, moving_up, moving_down, busy, bad_req}), 0);
    check("rst_addr", int'(addr), 0);
    @(negedge clk) reset = 1'b0;
    bad_cnt = 0;
    for (int c = 0; c < 20; c++) begin
      if (busy || shift || door_open || moving_up || moving_down || floor != 4'd1) bad_cnt++;
      @(negedge clk);
    end
    check("idle_hold", bad_cnt, 0);

    // Directed table: single-entry queues served back to back from the current floor.
    for (int v = 0; v < 7; v++) begin
      for (int i = 0; i < 16; i++) load_vals[i] = 4'd0;
      load_vals[0] = vecs[v].req;
      pulse_load();
      up_c = 0; down_c = 0; door_c = 0; shift_c = 0; bad_c = 0; busy_c = 0; both_c = 0;
      started = 0; done = 0;
      for (int c = 0; c < 400 && done == 0; c++) begin
        if (busy) begin
          started = 1;
          busy_c++;
          if (moving_up) up_c++;
          if (moving_down) down_c++;
          if (door_open) door_c++;
          if (moving_up && moving_down) both_c++;
        end else if (started != 0) begin
          done = 1;
        end
        if (shift) shift_c++;
        if (bad_req) bad_c++;
        if (done == 0) @(negedge clk);
      end
      check($sformatf("v%0d_done", v), done, 1);
      check($sformatf("v%0d_up", v), up_c, vecs[v].up_c);
      check($sformatf("v%0d_down", v), down_c, vecs[v].down_c);
      check($sformatf("v%0d_door", v), door_c, vecs[v].door_c);
      check($sformatf("v%0d_shift", v), shift_c, vecs[v].shift_c);
      check($sformatf("v%0d_bad", v), bad_c, vecs[v].bad_c);
      check($sformatf("v%0d_busy", v), busy_c, vecs[v].busy_c);
      check($sformatf("v%0d_excl", v), both_c, 0);
      check($sformatf("v%0d_floor", v), int'(floor), vecs[v].fin);
    end

    // Head insert en route: heading to 9, a stop at 3 appears after the floor-2 step.
    do_reset();
    for (int i = 0; i < 16; i++) load_vals[i] = 4'd0;
    load_vals[0] = 4'd9;
    load_vals[1] = 4'd5;
    pulse_load();
    door_n = 0; shift_c = 0; prev_door = 0; inserted = 0;
    for (int i = 0; i < 3; i++) doors[i] = 0;
    for (int c = 0; c < 800; c++) begin
      if (floor == 4'd2 && inserted == 0) begin
        ins_val  = 4'd3;
        ins_en   = 1'b1;
        inserted = 1;
      end else begin
        ins_en = 1'b0;
      end
      if (door_open && prev_door == 0) begin
        if (door_n < 3) doors[door_n] = int'(floor);
        door_n++;
      end
      prev_door = int'(door_open);
      if (shift) shift_c++;
      if (door_n >= 3 && !busy && q == 4'd0) break;
      @(negedge clk);
    end
    ins_en = 1'b0;
    check("ins_doors", door_n, 3);
    check("ins_door0", doors[0], 3);
    check("ins_door1", doors[1], 9);
    check("ins_door2", doors[2], 5);
    check("ins_shifts", shift_c, 3);

    // Reset between floors 5 and 6: outputs clear at once, entry is kept and re-served.
    do_reset();
    for (int i = 0; i < 16; i++) load_vals[i] = 4'd0;
    load_vals[0] = 4'd8;
    pulse_load();
    shift_c = 0;
    for (int c = 0; c < 200 && floor != 4'd5; c++) begin
      if (shift) shift_c++;
      @(negedge clk);
    end
    check("rmv_reach5", int'(floor), 5);
    repeat (2) begin
      @(negedge clk);
      if (shift) shift_c++;
    end
    check("rmv_moving", int'(moving_up), 1);
    reset = 1'b1;
    #1;
    check("rmv_floor", int'(floor), 1);
    check("rmv_outs", int'({shift, door_open, moving_up, moving_down, busy, bad_req}), 0);
    check("rmv_noshift", shift_c, 0);
    @(negedge clk) reset = 1'b0;
    for (int c = 0; c < 200 && !door_open; c++) @(negedge clk);
    check("rmv_reserve", int'(floor), 8);
    for (int c = 0; c < 50 && busy; c++) @(negedge clk);
    check("rmv_idle", int'(busy), 0);

    // Randomized queues against a schedule computed from the serving-time rules.
    for (int r = 0; r < 4; r++) begin
      do_reset();
      n = $urandom_range(4, 12);
      for (int i = 0; i < 16; i++) rq[i] = 4'd0;
      for (int i = 0; i < n; i++) rq[i] = 4'($urandom_range(1, 15));
      for (int i = 0; i < 16; i++) load_vals[i] = rq[i];
      exp_q.delete();
      f = 1;
      exp_q.push_back(pack(4'(f), 0, 0, 0, 0, 0, 0));
      for (int i = 0; i < n; i++) begin
        e = int'(rq[i]);
        if (e > TOPF) begin
          exp_q.push_back(pack(4'(f), 0, 0, 0, 1, 1, 1));
          exp_q.push_back(pack(4'(f), 0, 0, 0, 0, 1, 0));
          exp_q.push_back(pack(4'(f), 0, 0, 0, 0, 0, 0));
        end else begin
          d = (e > f) ? e - f : f - e;
          for (int j = 0; j < d * T_CYC; j++) begin
            if (e > f) exp_q.push_back(pack(4'(f + j / T_CYC), 1, 0, 0, 0, 1, 0));
            else       exp_q.push_back(pack(4'(f - j / T_CYC), 0, 1, 0, 0, 1, 0));
          end
          for (int j = 0; j < D_CYC; j++) exp_q.push_back(pack(4'(e), 0, 0, 1, 0, 1, 0));
          exp_q.push_back(pack(4'(e), 0, 0, 0, 1, 1, 0));
          exp_q.push_back(pack(4'(e), 0, 0, 0, 0, 1, 0));
          exp_q.push_back(pack(4'(e), 0, 0, 0, 0, 0, 0));
          f = e;
        end
      end
      for (int j = 0; j < 5; j++) exp_q.push_back(pack(4'(f), 0, 0, 0, 0, 0, 0));
      pulse_load();
      bad_cnt = 0;
      for (int c = 0; c < exp_q.size(); c++) begin
        checks++;
        if (pack(floor, moving_up, moving_down, door_open, shift, busy, bad_req) !== exp_q[c]) begin
          errors++;
          bad_cnt++;
          $display("FAIL rand%0d_cyc%0d: got {fl,up,dn,door,sh,busy,bad}=%b, expected %b",
                   r, c, pack(floor, moving_up, moving_down, door_open, shift, busy, bad_req),
                   exp_q[c]);
        end
        @(negedge clk);
      end
      $display("rand round %0d: %0d entries, %0d cycles, %0d mismatched cycles",
               r, n, exp_q.size(), bad_cnt);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/elevator_queue_reader.md
# elevator_queue_reader

Consumer end of the elevator request queue: reads the head entry of the 16x4 request RAM, drives the car floor-by-floor to that floor, holds the door open, then pops the entry with a one-cycle `shift` pulse. The queue writer (append/insert logic) fills the RAM. This block is the only agent that removes entries, and it owns the car position and motion outputs.

## Interface
- `TRAVEL_CYCLES`, 4: clock cycles per floor of travel, ≥1.
- `DOOR_CYCLES`, 8: clock cycles the door stays open, ≥1.
- `TOP_FLOOR`, 15: highest valid floor code, 1..15.

Ports (all buses unsigned):
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `q`  in  4  head-of-queue entry from the RAM read port. 0 means the queue is empty. 1..15 is a floor code.
- `addr`  out  4  RAM read address; constant 4'd0 (queue head).
- `shift`  out  1  one-cycle pop pulse to the RAM.
- `floor`  out  4  current car floor.
- `moving_up`  out  1  car is travelling up.
- `moving_down`  out  1  car is travelling down.
- `door_open`  out  1  door is open.
- `busy`  out  1  high in every state except IDLE.
- `bad_req`  out  1  one-cycle pulse when an out-of-range head entry is discarded.

## Operation
- FSM states: IDLE, MOVE, DOOR, POP, SETTLE.
- Registers: `target[3:0]`, `floor[3:0]`, and one shared down-counter `timer`.
- **IDLE**
  - q == 0: stay in IDLE.
  - q > TOP_FLOOR: go to POP and pulse `bad_req` on the same edge.
  - q == floor: go to DOOR.
  - Otherwise: latch `target` = q, load `timer` = TRAVEL_CYCLES−1, go to MOVE.
- **MOVE**
  - Direction is `target > floor` → up, else down.
  - `timer` decrements each cycle. At `timer` == 0, `floor` steps ±1 on that edge.
  - At each floor step, `target` is re-read from q if q is nonzero and in range. This lets a stop inserted at the head by the writer be served en route.
  - If the new floor equals the (re-read) target: go to DOOR. Otherwise reload `timer` and continue.
  - q == 0 in MOVE: hold the current `target`.
- **DOOR**
  - Load `timer` = DOOR_CYCLES−1 on entry.
  - `door_open` stays high until `timer` reaches 0, then go to POP.
- **POP**: `shift` = 1 for exactly this cycle, then go to SETTLE.
- **SETTLE**: one idle cycle so the updated head propagates to q, then go to IDLE.
- `moving_up` and `moving_down` are never high together. Both are 0 outside MOVE.
- `floor` never leaves 1..TOP_FLOOR.
- `addr` is constant 0 and is not affected by reset.

## Timing
- Reset values: state IDLE, `floor` = 1, `target` = 1, `timer` = 0; `shift`, `door_open`, `moving_up`, `moving_down`, `busy`, `bad_req` all 0.
- Reset asserted mid-operation: return to these values immediately (asynchronous). No `shift` is emitted, and the head entry is retained.
- All outputs are registered or decoded from registered state; no combinational path from q to any output.
- Travel latency: entering MOVE at edge k, the first floor step occurs at edge k+TRAVEL_CYCLES. Each subsequent step follows TRAVEL_CYCLES edges later.
- Request serving time: a request |Δ| floors away, seen in IDLE at edge k, gives:
  - door opens at edge k+|Δ|·TRAVEL_CYCLES;
  - `shift` high in the cycle after edge k+|Δ|·TRAVEL_CYCLES+DOOR_CYCLES;
  - back in IDLE two edges after that.
- Same-floor request: DOOR from the next edge; no motion.
- `bad_req` path: IDLE → POP → SETTLE → IDLE, 3 cycles, with the `bad_req` pulse coinciding with the POP entry edge.
- Only one `shift` is issued per consumed entry. `shift` is never issued in IDLE, MOVE or DOOR.
- Writer appends/inserts concurrent with POP are permitted. The SETTLE cycle guarantees q is re-sampled only after the RAM has updated.

## Structure
- Shared package `elevator_pkg`:
  - state enum `reader_state_t`;
  - `EMPTY_SLOT` = 4'd0;
  - `GROUND_FLOOR` = 4'd1;
  - the floor width constant, shared with the queue writer.
- One sub-module, `cycle_timer`: loadable down-counter with load value, enable and `zero` flag. It is instantiated once and shared by MOVE and DOOR.

## Test plan
- Reset, then q = 0 for 20 cycles → stays IDLE; `floor` = 1; `busy`, `shift`, `door_open` all 0.
- q = 4, TRAVEL_CYCLES = 4, DOOR_CYCLES = 8 → `moving_up` for 12 cycles, `floor` steps 2, 3, 4, `door_open` 8 cycles, one `shift` pulse, IDLE; `floor` = 4.
- From floor 4, q = 4 → no motion, `door_open` 8 cycles, one `shift`.
- Heading to 9 from floor 1; after the floor-2 step, q changes to 3 (head insert) → door opens at floor 3, only one `shift`; the next head entry is then served.
- TOP_FLOOR = 10, q = 12 → `bad_req` pulse, `shift` pulse, no motion, IDLE after 3 cycles.
- `reset` asserted during MOVE between floors 5 and 6 → immediately `floor` = 1, all outputs 0, no `shift`.
